mem_wb_skid_stage: RTL
======================

MEM_WB_SKID_STAGE -- requirements
Module: mem_wb_skid_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the read-data and ALU-result fields.
REQ-002 SHALL have parameter REG_AW, default 5: width of the destination register index.
REQ-003 SHALL have parameter ZERO_KILL, default 1: when 1, a writeback to register index 0 is suppressed.
REQ-004 SHALL have one clock; reset is asynchronous and active-low (clk, rst_n).
REQ-005 Ports: clk  in  1  rising-edge clock.
REQ-006 Ports: rst_n  in  1  asynchronous active-low reset.
REQ-007 Ports: in_valid  in  1  upstream MEM entry present.
REQ-008 Ports: in_ready  out  1  stage can accept an entry; registered output.
REQ-009 Ports: in_wb_ctrl  in  2  bit0 MemtoReg, bit1 RegWrite.
REQ-010 Ports: in_read_data  in  DATA_W  memory load data.
REQ-011 Ports: in_alu_result  in  DATA_W  ALU result.
REQ-012 Ports: in_dest  in  REG_AW  destination register index.
REQ-013 Ports: flush  in  1  discard all held and incoming entries.
REQ-014 Ports: out_valid  out  1  WB entry present.
REQ-015 Ports: out_ready  in  1  writeback consumes the entry.
REQ-016 Ports: out_mem_to_reg, out_reg_write  out  1 each  WB controls of the head entry.
REQ-017 Ports: out_read_data, out_alu_result  out  DATA_W each  head-entry payload.
REQ-018 Ports: out_dest  out  REG_AW  head-entry destination.
REQ-019 Ports: out_wb_data  out  DATA_W  out_read_data if out_mem_to_reg, else out_alu_result.
REQ-020 Ports: occupancy  out  2  number of held entries, 0..2.

Function
REQ-021 Storage SHALL be two entries, main (head) and skid, each holding {valid, ctrl, read_data, alu_result, dest}.
REQ-022 An accept SHALL occur when in_valid && in_ready && !flush; a retire SHALL occur when out_valid && out_ready && !flush.
REQ-023 in_ready SHALL equal !skid.valid, registered; combinational paths from out_ready to in_ready are forbidden.
REQ-024 Accept with main empty, or with main retiring in the same cycle while skid is empty: data SHALL load into main; latency is 1 cycle, in to out.
REQ-025 Accept while main is held (no retire): data SHALL load into skid and in_ready SHALL drop next cycle.
REQ-026 Retire with skid valid: skid SHALL move to main and skid SHALL clear; in_ready SHALL rise next cycle.
REQ-027 Simultaneous retire and accept with skid valid is impossible, because in_ready is 0 then; with skid empty, main SHALL take the new entry.
REQ-028 Order SHALL be strictly FIFO; no entry may be dropped or duplicated absent flush.
REQ-029 flush SHALL clear both valid bits next cycle, discard any same-cycle input, and set in_ready=1; flush has priority over all other events.
REQ-030 out_valid SHALL equal main.valid; payload outputs SHALL be driven only from main registers.
REQ-031 out_reg_write SHALL be main.ctrl[1] && main.valid && !(ZERO_KILL && main.dest==0).
REQ-032 out_mem_to_reg SHALL be main.ctrl[0] && main.valid.
REQ-033 Payload registers SHALL hold their value while out_valid && !out_ready (stall).
REQ-034 occupancy SHALL equal main.valid + skid.valid.

Reset
REQ-035 While rst_n=0, all valid bits SHALL be 0; in_ready=1; out_valid=0, out_reg_write=0, out_mem_to_reg=0; occupancy=0.
REQ-036 While rst_n=0, payload registers (read_data, alu_result, dest) SHALL be 0, so out_wb_data=0.
REQ-037 Reset assertion mid-transfer SHALL discard all entries immediately; the first accept is possible in the first cycle after deassertion.

Structure
REQ-038 WB control bit positions (MEMTOREG_BIT=0, REGWRITE_BIT=1) and the entry struct typedef SHALL reside in shared package pipe_pkg, reused by the other pipeline registers.
REQ-039 One sub-module, skid_entry_reg, SHALL implement a single entry (load-enable, clear, async reset); it is instantiated twice.

Verification
REQ-040 Streaming: out_ready=1, 4 back-to-back entries dest=1..4 -> out_dest 1..4 on consecutive cycles, each 1 cycle after input; occupancy never exceeds 1.
REQ-041 Backpressure: out_ready=0, send A(alu=0x11) and B(alu=0x22) -> occupancy=2, in_ready=0, out_alu_result holds 0x11; raise out_ready -> 0x11 then 0x22 retire, in_ready returns to 1.
REQ-042 Flush: occupancy=2 plus in_valid with flush=1 -> next cycle occupancy=0, out_valid=0, in_ready=1; the flushed input never appears.
REQ-043 Zero kill: ctrl=2'b10, dest=0 -> out_valid=1, out_reg_write=0; same with dest=5 -> out_reg_write=1.
REQ-044 WB mux: ctrl=2'b11, read_data=0xDEADBEEF, alu=0x1234 -> out_wb_data=0xDEADBEEF; ctrl=2'b10 -> out_wb_data=0x1234.
REQ-045 Async reset: assert rst_n=0 mid-clock with occupancy=2 -> out_valid=0 and in_ready=1 before the next edge; after release, entries stream normally.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the pipeline-register stages.
//   MEMTOREG_BIT / REGWRITE_BIT : bit positions inside the 2-bit WB control field
//   PIPE_MAX_DATA_W / PIPE_MAX_REG_AW : widest payload / register index a stage may use
//   wb_entry_t : one held pipeline entry {valid, ctrl, read_data, alu_result, dest}
// The entry struct is sized for the widest configuration. Narrower stages
// zero-extend into it and slice back out, so one typedef serves every stage.
package pipe_pkg;

  localparam int MEMTOREG_BIT    = 0;
  localparam int REGWRITE_BIT    = 1;
  localparam int WB_CTRL_W       = 2;
  localparam int PIPE_MAX_DATA_W = 64;
  localparam int PIPE_MAX_REG_AW = 8;

  typedef struct packed {
    logic                       valid;
    logic [WB_CTRL_W-1:0]       ctrl;
    logic [PIPE_MAX_DATA_W-1:0] read_data;
    logic [PIPE_MAX_DATA_W-1:0] alu_result;
    logic [PIPE_MAX_REG_AW-1:0] dest;
  } wb_entry_t;

endpackage

// File: rtl/skid_entry_reg.sv
// skid_entry_reg: one storage slot of the MEM/WB skid buffer.
//   clk, rst_n : clock, asynchronous active-low reset (clears the whole entry)
//   load       : capture entry_d on the next rising edge
//   clr        : drop the valid bit on the next rising edge (wins over load)
//   entry_d    : entry to capture
//   entry_q    : held entry
// clr only drops the valid bit. The payload keeps its last value because
// nothing downstream looks at it while valid is low.
module skid_entry_reg
  import pipe_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      load,
  input  logic      clr,
  input  wb_entry_t entry_d,
  output wb_entry_t entry_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= '0;
    end else if (clr) begin
      entry_q.valid <= 1'b0;
    end else if (load) begin
      entry_q <= entry_d;
    end
  end

endmodule

// File: rtl/mem_wb_skid_stage.sv
// mem_wb_skid_stage: MEM->WB pipeline register with a two-entry skid buffer.
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid / in_ready    : upstream handshake (in_ready comes from a flop)
//   in_wb_ctrl             : bit0 MemtoReg, bit1 RegWrite
//   in_read_data, in_alu_result, in_dest : incoming payload
//   flush                  : drop every held entry and the current input
//   out_valid / out_ready  : writeback handshake
//   out_mem_to_reg, out_reg_write, out_read_data, out_alu_result, out_dest :
//                            head (main) entry
//   out_wb_data            : selected writeback value
//   occupancy              : held entries, 0..2
// The head entry always lives in "main". "skid" only fills when main is
// stalled. in_ready is simply !skid.valid, so out_ready never reaches
// in_ready combinationally.
// DATA_W must not exceed PIPE_MAX_DATA_W, and REG_AW must not exceed PIPE_MAX_REG_AW.
module mem_wb_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int ZERO_KILL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_wb_ctrl,
  input  logic [DATA_W-1:0] in_read_data,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [REG_AW-1:0] in_dest,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_mem_to_reg,
  output logic              out_reg_write,
  output logic [DATA_W-1:0] out_read_data,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [REG_AW-1:0] out_dest,
  output logic [DATA_W-1:0] out_wb_data,
  output logic [1:0]        occupancy
);

  wb_entry_t in_entry;
  wb_entry_t main_d, main_q;
  wb_entry_t skid_d, skid_q;
  logic      main_load, main_clr;
  logic      skid_load, skid_clr;
  logic      accept, retire;

  always_comb begin
    in_entry            = '0;
    in_entry.valid      = 1'b1;
    in_entry.ctrl       = in_wb_ctrl;
    in_entry.read_data  = PIPE_MAX_DATA_W'(in_read_data);
    in_entry.alu_result = PIPE_MAX_DATA_W'(in_alu_result);
    in_entry.dest       = PIPE_MAX_REG_AW'(in_dest);
  end

  assign accept = in_valid && in_ready && !flush;
  assign retire = main_q.valid && out_ready && !flush;

  always_comb begin
    main_load = 1'b0;
    main_clr  = 1'b0;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    main_d    = in_entry;
    skid_d    = in_entry;

    if (flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else if (retire) begin
      if (skid_q.valid) begin
        // Promote the skid entry. in_ready is low here, so no accept can happen.
        main_load = 1'b1;
        main_d    = skid_q;
        skid_clr  = 1'b1;
      end else if (accept) begin
        main_load = 1'b1;
      end else begin
        main_clr  = 1'b1;
      end
    end else if (accept) begin
      if (main_q.valid) begin
        skid_load = 1'b1;
      end else begin
        main_load = 1'b1;
      end
    end
  end

  skid_entry_reg u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (main_load),
    .clr     (main_clr),
    .entry_d (main_d),
    .entry_q (main_q)
  );

  skid_entry_reg u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (skid_load),
    .clr     (skid_clr),
    .entry_d (skid_d),
    .entry_q (skid_q)
  );

  assign in_ready       = !skid_q.valid;
  assign out_valid      = main_q.valid;
  assign out_mem_to_reg = main_q.valid && main_q.ctrl[MEMTOREG_BIT];
  assign out_reg_write  = main_q.valid && main_q.ctrl[REGWRITE_BIT] &&
                          !((ZERO_KILL != 0) && (main_q.dest[REG_AW-1:0] == '0));
  assign out_read_data  = main_q.read_data[DATA_W-1:0];
  assign out_alu_result = main_q.alu_result[DATA_W-1:0];
  assign out_dest       = main_q.dest[REG_AW-1:0];
  assign out_wb_data    = out_mem_to_reg ? out_read_data : out_alu_result;
  assign occupancy      = {1'b0, main_q.valid} + {1'b0, skid_q.valid};

  // Upper struct bits above DATA_W / REG_AW are intentionally dropped.
  logic unused_main_bits;
  assign unused_main_bits = ^{main_q.read_data, main_q.alu_result, main_q.dest};

endmodule
